// File: rtl/block_spi_master_if.sv
// Word stream into the SPI master: tx words in with valid/ready/last, received words out.
// The block is the slave of this stream; the feeding logic uses the master modport.
interface block_spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/block_spi_master.sv
// Mode-0 SPI master (CPOL=0, CPHA=0, MSB first) fed from a valid/ready word stream.
// SS is held low across a burst until a word tagged last has finished.
module block_spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  block_spi_master_if.slave stream,
  output logic              busy,
  output logic              SPI_SCK,
  output logic              SPI_SS,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LO    = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] TRAIL = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  logic [2:0]            state_reg, state_next;
  logic [CW-1:0]         div_cnt_reg, div_cnt_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_WIDTH-1:0] rx_shift_reg, rx_shift_next;
  logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
  logic                  last_reg, last_next;
  logic                  rx_valid_reg, rx_valid_next;
  logic                  sck_reg, sck_next;
  logic                  ss_reg, ss_next;

  logic [DATA_WIDTH-1:0] tx_shifted;
  logic [DATA_WIDTH-1:0] rx_shifted;
  logic                  tx_ready;
  logic                  accept;
  logic                  div_done;

  // One-bit-advanced copies of both shift registers; MISO enters at the LSB.
  assign tx_shifted[0] = 1'b0;
  assign rx_shifted[0] = SPI_MISO;
  genvar gi;
  generate
    for (gi = 1; gi < DATA_WIDTH; gi++) begin : g_shift
      assign tx_shifted[gi] = tx_shift_reg[gi-1];
      assign rx_shifted[gi] = rx_shift_reg[gi-1];
    end
  endgenerate

  assign tx_ready = ((state_reg == IDLE) || (state_reg == WAIT)) && !rst;
  assign accept   = stream.tx_valid && tx_ready;
  assign div_done = (div_cnt_reg == DIV_LAST);

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    last_next     = last_reg;
    rx_valid_next = 1'b0;
    sck_next      = sck_reg;
    ss_next       = ss_reg;

    case (state_reg)
      IDLE, WAIT: begin
        if (accept) begin
          tx_shift_next = stream.tx_data;
          last_next     = stream.tx_last;
          ss_next       = 1'b0;
          div_cnt_next  = '0;
          bit_cnt_next  = '0;
          state_next    = LO;
        end
      end
      LO: begin
        if (div_done) begin
          div_cnt_next  = '0;
          sck_next      = 1'b1;
          rx_shift_next = rx_shifted;
          state_next    = HI;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      HI: begin
        if (div_done) begin
          div_cnt_next = '0;
          sck_next     = 1'b0;
          if (bit_cnt_reg == BIT_LAST) begin
            // MOSI keeps the final bit through WAIT/TRAIL/GAP.
            rx_data_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
            state_next    = last_reg ? TRAIL : WAIT;
          end else begin
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            tx_shift_next = tx_shifted;
            state_next    = LO;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      TRAIL: begin
        if (div_done) begin
          div_cnt_next = '0;
          ss_next      = 1'b1;
          state_next   = GAP;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (div_done) begin
          div_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      last_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      sck_reg      <= 1'b0;
      ss_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      last_reg     <= last_next;
      rx_valid_reg <= rx_valid_next;
      sck_reg      <= sck_next;
      ss_reg       <= ss_next;
    end
  end

  // MOSI comes straight from the shift register MSB, so it is glitch-free.
  assign SPI_MOSI        = tx_shift_reg[DATA_WIDTH-1];
  assign SPI_SCK         = sck_reg;
  assign SPI_SS          = ss_reg;
  assign busy            = (state_reg != IDLE);
  assign stream.tx_ready = tx_ready;
  assign stream.rx_data  = rx_data_reg;
  assign stream.rx_valid = rx_valid_reg;
endmodule

// File: tb/tb_block_spi_master.sv
// Bench for block_spi_master: a CLK_DIV=4 instance with a queued slave model and a
// CLK_DIV=1 instance wired in MISO/MOSI loopback.
module tb_block_spi_master;
  localparam int DW      = 8;
  localparam int DIV     = 4;
  localparam int RX_LAT  = 2 * DW * DIV;
  localparam int SS_LAT  = RX_LAT + DIV;
  localparam int RDY_LAT = (2 * DW + 2) * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, busy, sck, ss, mosi, miso;
  logic rst1, busy1, sck1, ss1, mosi1, miso1;
  assign miso1 = mosi1;

  block_spi_master_if #(.DATA_WIDTH(DW)) s0 ();
  block_spi_master_if #(.DATA_WIDTH(DW)) s1 ();

  block_spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) u0 (
    .clk(clk), .rst(rst), .stream(s0), .busy(busy),
    .SPI_SCK(sck), .SPI_SS(ss), .SPI_MOSI(mosi), .SPI_MISO(miso));

  block_spi_master #(.DATA_WIDTH(DW), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst1), .stream(s1), .busy(busy1),
    .SPI_SCK(sck1), .SPI_SS(ss1), .SPI_MOSI(mosi1), .SPI_MISO(miso1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Slave model and bus monitor for u0, evaluated once per cycle away from the active edge.
  logic [7:0] slave_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] rx_dat_q[$];
  int rx_cyc_q[$];
  int ss_cyc_q[$];
  int rdy_cyc_q[$];
  int sck_rises = 0;
  int ss_rises = 0;
  int rx_pulses = 0;
  int hi_min, hi_max, lo_min, lo_max;

  initial begin
    logic [7:0] miso_byte, mosi_acc;
    int bit_idx, mosi_cnt, hi_len, lo_len;
    bit loaded, prev_sck, prev_ss, prev_rdy;
    miso = 1'b0; miso_byte = '0; mosi_acc = '0;
    bit_idx = 0; mosi_cnt = 0; hi_len = 0; lo_len = 0;
    loaded = 0; prev_sck = 0; prev_ss = 1; prev_rdy = 0;
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    forever begin
      @(negedge clk);
      if (!ss && prev_ss) begin
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
      end
      if (sck && !prev_sck) begin
        sck_rises++;
        mosi_acc = {mosi_acc[6:0], mosi};
        mosi_cnt++;
        if (mosi_cnt == 8) begin
          mosi_q.push_back(mosi_acc);
          mosi_cnt = 0;
        end
        if (!loaded) begin
          miso_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
          loaded = 1;
        end
        if (lo_len < lo_min) lo_min = lo_len;
        if (lo_len > lo_max) lo_max = lo_len;
        lo_len = 0;
      end
      if (!sck && prev_sck) begin
        bit_idx++;
        if (hi_len < hi_min) hi_min = hi_len;
        if (hi_len > hi_max) hi_max = hi_len;
        hi_len = 0;
        if (bit_idx == 8) begin
          bit_idx = 0;
          loaded = 0;
        end
      end
      if (sck) hi_len++;
      else if (!ss) lo_len++;
      if (ss) begin
        bit_idx = 0; loaded = 0; mosi_cnt = 0; lo_len = 0;
      end
      if (ss && !prev_ss) begin
        ss_rises++;
        ss_cyc_q.push_back(cyc);
      end
      if (s0.tx_ready && !prev_rdy) rdy_cyc_q.push_back(cyc);
      if (s0.rx_valid) begin
        rx_pulses++;
        rx_cyc_q.push_back(cyc);
        rx_dat_q.push_back(s0.rx_data);
      end
      prev_sck = sck; prev_ss = ss; prev_rdy = s0.tx_ready;
      miso = loaded ? miso_byte[7-bit_idx] : ((slave_q.size() > 0) ? slave_q[0][7] : 1'b0);
    end
  end

  function automatic int ev_count(input int which);
    case (which)
      0:       return rx_cyc_q.size();
      1:       return ss_cyc_q.size();
      default: return rdy_cyc_q.size();
    endcase
  endfunction

  // which: 0 = rx_valid pulse, 1 = SS rising, 2 = tx_ready rising
  task automatic wait_event(input int which, output int c, output logic [7:0] d);
    int n;
    n = 0; c = -1; d = 8'h00;
    while (ev_count(which) == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ev_count(which) == 0) begin
      checks++;
      errors++;
      $display("FAIL event_timeout: event %0d not seen within %0d cycles", which, n);
    end else begin
      case (which)
        0: begin c = rx_cyc_q.pop_front(); d = rx_dat_q.pop_front(); end
        1: c = ss_cyc_q.pop_front();
        default: c = rdy_cyc_q.pop_front();
      endcase
    end
  endtask

  function automatic logic [31:0] pop_mosi();
    if (mosi_q.size() == 0) return 32'hFFFF_FFFF;
    return {24'h0, mosi_q.pop_front()};
  endfunction

  task automatic present(input logic [7:0] d, input logic last);
    s0.tx_data = d;
    s0.tx_last = last;
    s0.tx_valid = 1'b1;
  endtask

  // Returns the accept edge number; the word in flight must ignore the scrambled inputs after it.
  task automatic wait_accept(output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!s0.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s0.tx_ready) check("accept_timeout", s0.tx_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    s0.tx_valid = 1'b0;
    s0.tx_data = 8'($urandom);
    s0.tx_last = 1'($urandom);
    ss_cyc_q.delete();
    rdy_cyc_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    int         rx_lat;
    int         ss_lat;
    int         rdy_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc, a2, rc, r2, sc, yc, bad, base_sck, base_ss, base_rx, n, gap;
    logic [7:0] rd, d, sl;
    logic lst;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, RX_LAT, SS_LAT, RDY_LAT};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF, RX_LAT, SS_LAT, RDY_LAT};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, RX_LAT, SS_LAT, RDY_LAT};
    vecs[3] = '{8'h80, 8'h01, 8'h01, RX_LAT, SS_LAT, RDY_LAT};

    // Reset with tx_valid asserted: nothing may be accepted.
    rst = 1'b1; rst1 = 1'b1;
    s0.tx_data = 8'hA5; s0.tx_last = 1'b1; s0.tx_valid = 1'b1;
    s1.tx_data = 8'h00; s1.tx_last = 1'b0; s1.tx_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx_ready", s0.tx_ready, 0);
      check("rst_ss", ss, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_rx_valid", s0.rx_valid, 0);
      check("rst_rx_data", s0.rx_data, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; rst1 = 1'b0; s0.tx_valid = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", s0.tx_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_ss", ss, 1);

    // Single words from idle, last=1.
    for (int i = 0; i < 4; i++) begin
      base_sck = sck_rises;
      base_rx = rx_pulses;
      slave_q.push_back(vecs[i].slave);
      @(posedge clk); #1;
      present(vecs[i].data, 1'b1);
      wait_accept(acc);
      wait_event(0, rc, rd);
      check("tbl_rx_data", rd, vecs[i].exp_rx);
      check("tbl_rx_lat", rc - acc, vecs[i].rx_lat);
      check("tbl_mosi", pop_mosi(), vecs[i].data);
      wait_event(1, sc, rd);
      check("tbl_ss_lat", sc - acc, vecs[i].ss_lat);
      wait_event(2, yc, rd);
      check("tbl_ready_lat", yc - acc, vecs[i].rdy_lat);
      check("tbl_sck_rises", sck_rises - base_sck, DW);
      check("tbl_rx_pulses", rx_pulses - base_rx, 1);
      check("tbl_hi_min", hi_min, DIV);
      check("tbl_hi_max", hi_max, DIV);
      check("tbl_lo_min", lo_min, DIV);
      check("tbl_lo_max", lo_max, DIV);
      $display("txn vec%0d tx=%02h rx=%02h rx_at=+%0d ss_at=+%0d ready_at=+%0d",
               i, vecs[i].data, vecs[i].exp_rx, rc - acc, sc - acc, yc - acc);
    end

    // Burst: second word presented while the first is in flight.
    base_sck = sck_rises; base_ss = ss_rises;
    slave_q.push_back(8'h11); slave_q.push_back(8'h22);
    @(posedge clk); #1;
    present(8'h33, 1'b0);
    wait_accept(acc);
    present(8'h34, 1'b1);
    wait_accept(a2);
    check("burst_accept_gap", a2 - acc, RX_LAT + 1);
    wait_event(0, rc, rd);
    check("burst_rx1", rd, 8'h11);
    check("burst_rx1_lat", rc - acc, RX_LAT);
    wait_event(0, r2, rd);
    check("burst_rx2", rd, 8'h22);
    check("burst_rx_gap", r2 - rc, RX_LAT + 1);
    check("burst_ss_low", ss_rises - base_ss, 0);
    wait_event(1, sc, rd);
    check("burst_ss_rise", sc - r2, DIV);
    check("burst_sck_rises", sck_rises - base_sck, 2 * DW);
    check("burst_mosi1", pop_mosi(), 8'h33);
    check("burst_mosi2", pop_mosi(), 8'h34);
    wait_event(2, yc, rd);
    $display("txn burst 33,34 rx=11,22 rx_gap=%0d", r2 - rc);

    // Stall in WAIT for 50 cycles between words of a burst.
    slave_q.push_back(8'hC6); slave_q.push_back(8'h0F);
    @(posedge clk); #1;
    present(8'h33, 1'b0);
    wait_accept(acc);
    wait_event(0, rc, rd);
    check("stall_rx1", rd, 8'hC6);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ss !== 1'b0 || sck !== 1'b0 || s0.tx_ready !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("stall_hold", bad, 0);
    @(posedge clk); #1;
    present(8'hFF, 1'b1);
    wait_accept(acc);
    wait_event(0, rc, rd);
    check("stall_rx2", rd, 8'h0F);
    check("stall_rx2_lat", rc - acc, RX_LAT);
    check("stall_mosi1", pop_mosi(), 8'h33);
    check("stall_mosi2", pop_mosi(), 8'hFF);
    wait_event(2, yc, rd);
    check("stall_ready_lat", yc - acc, RDY_LAT);
    $display("txn stall 33,(50 idle),FF rx=C6,0F");

    // Reset after the third SCK rise aborts the word without an rx pulse.
    slave_q.push_back(8'h99);
    base_sck = sck_rises;
    @(posedge clk); #1;
    present(8'hC3, 1'b1);
    wait_accept(acc);
    n = 0;
    while (sck_rises - base_sck < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    base_rx = rx_pulses;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss", ss, 1);
    check("abort_sck", sck, 0);
    check("abort_rx_valid", s0.rx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_ready", s0.tx_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_back", s0.tx_ready, 1);
    check("abort_no_rx", rx_pulses - base_rx, 0);
    check("abort_no_mosi_word", mosi_q.size(), 0);
    rx_cyc_q.delete(); rx_dat_q.delete();
    slave_q.push_back(8'h5E);
    @(posedge clk); #1;
    present(8'h81, 1'b1);
    wait_accept(acc);
    wait_event(0, rc, rd);
    check("after_abort_rx", rd, 8'h5E);
    check("after_abort_lat", rc - acc, RX_LAT);
    check("after_abort_mosi", pop_mosi(), 8'h81);
    wait_event(2, yc, rd);
    $display("txn abort C3 then 81 rx=%02h", rd);

    // Randomized bursts against the queue model.
    base_sck = sck_rises; base_ss = ss_rises;
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      sl = 8'($urandom);
      lst = (i == 29) || ($urandom_range(0, 2) == 0);
      slave_q.push_back(sl);
      exp_rx_q.push_back(sl);
      exp_tx_q.push_back(d);
      gap = $urandom_range(0, 5);
      repeat (gap) @(posedge clk);
      @(posedge clk); #1;
      present(d, lst);
      wait_accept(acc);
      wait_event(0, rc, rd);
      check("rnd_rx", rd, exp_rx_q.pop_front());
      check("rnd_rx_lat", rc - acc, RX_LAT);
      check("rnd_mosi", pop_mosi(), exp_tx_q.pop_front());
      if (lst) begin
        wait_event(1, sc, rd);
        check("rnd_ss_lat", sc - rc, DIV);
        wait_event(2, yc, rd);
        check("rnd_ready_lat", yc - acc, RDY_LAT);
      end
      $display("txn rnd%0d tx=%02h last=%0b rx=%02h exp=%02h", i, d, lst, rd, sl);
    end
    check("rnd_sck_total", sck_rises - base_sck, 30 * DW);

    // CLK_DIV=1 instance, loopback: rx must equal tx.
    begin
      int acc1, rx1, rdy1, rises1, long1;
      logic [7:0] rd1;
      bit p_sck, p_rdy;
      @(posedge clk); #1;
      s1.tx_data = 8'h5A; s1.tx_last = 1'b1; s1.tx_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s1.tx_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("div1_ready", s1.tx_ready, 1);
      @(posedge clk); #1;
      acc1 = cyc;
      s1.tx_valid = 1'b0; s1.tx_data = 8'h00;
      rx1 = -1; rdy1 = -1; rises1 = 0; long1 = 0; rd1 = 8'h00;
      p_sck = 0; p_rdy = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (sck1 && !p_sck) rises1++;
        if (sck1 && p_sck) long1++;
        if (s1.rx_valid && rx1 < 0) begin
          rx1 = cyc;
          rd1 = s1.rx_data;
        end
        if (s1.tx_ready && !p_rdy && rdy1 < 0) rdy1 = cyc;
        p_sck = sck1; p_rdy = s1.tx_ready;
      end
      check("div1_rx_lat", rx1 - acc1, 2 * DW);
      check("div1_rx_data", rd1, 8'h5A);
      check("div1_sck_rises", rises1, DW);
      check("div1_sck_high_1clk", long1, 0);
      check("div1_ready_lat", rdy1 - acc1, 2 * DW + 2);
      $display("txn div1 tx=5A rx=%02h rx_at=+%0d ready_at=+%0d", rd1, rx1 - acc1, rdy1 - acc1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/block_spi_master.md
Name: block_spi_master

Overview:
- SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that drives the external SPI bus toward the slave-side logic and sensor front-end.
- Takes bytes from a valid/ready stream and shifts them out on MOSI. Captures MISO into a received byte per transfer.
- SS stays low across a multi-byte burst until a byte tagged last completes.
- Sits between the system-clock fabric (FIFO read side) and the SPI pins.

Parameters:
- DATA_WIDTH, 8: bits per transfer word.
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_valid  in  1  tx_data/tx_last are valid.
- tx_last  in  1  deassert SS after this word.
- tx_ready  out  1  block accepts a word this cycle.
- rx_data  out  DATA_WIDTH  last received word; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- busy  out  1  high when state is not IDLE.
- SPI_SCK  out  1  serial clock; idles low.
- SPI_SS  out  1  slave select, active low.
- SPI_MOSI  out  1  serial data out.
- SPI_MISO  in  1  serial data in.

Behaviour:
- Reset, while rst is high and on the first cycle after: SPI_SS=1, SPI_SCK=0, SPI_MOSI=0, rx_valid=0, rx_data=0, busy=0, state=IDLE.
- tx_ready is gated low while rst=1. Reset mid-transfer aborts immediately; no partial rx_valid is produced.
- tx_ready = (state==IDLE or state==WAIT) and !rst. A word is accepted on any edge where tx_valid && tx_ready.
- States: IDLE, LO, HI, WAIT, TRAIL, GAP. A half-period counter runs from 0 to CLK_DIV-1. A bit counter runs from 0 to DATA_WIDTH-1.
- IDLE, on accept:
  - Load tx shift register.
  - Latch tx_last.
  - Set SS<=0 and MOSI<=tx_data[MSB].
  - Go to LO. This gives one half-period of SS-to-SCK setup.
- LO, after CLK_DIV cycles:
  - Set SCK<=1.
  - Shift SPI_MISO (sampled on this clk edge) into the rx shift register LSB.
  - Go to HI.
- HI, after CLK_DIV cycles, SCK<=0, then:
  - If bits remain: MOSI<=next bit, go to LO.
  - After the final bit: rx_data<=rx shift register, rx_valid<=1 for one cycle.
  - Then go to TRAIL if the latched last flag is set, otherwise go to WAIT.
- Latency: the accept edge is k. The final SCK fall and rx_valid are registered on edge k + 2*DATA_WIDTH*CLK_DIV (k+64 at defaults).
- WAIT:
  - SS stays 0, SCK stays 0, MOSI holds its value.
  - Waits indefinitely for tx_valid. On accept, loads the word, drives the MSB and goes to LO, identical to IDLE but with SS already low.
  - Earliest back-to-back accept is one cycle after rx_valid.
- TRAIL: CLK_DIV cycles with SS=0 (hold time), then SS<=1, go to GAP.
- GAP: CLK_DIV cycles with SS=1 (minimum deselect time), then go to IDLE. tx_ready returns at k + (2*DATA_WIDTH+2)*CLK_DIV.
- tx_data is captured only at accept. Changing tx_data or tx_valid afterwards has no effect on the word in flight.
- Exactly DATA_WIDTH SCK rising edges occur per word. No SCK edges occur in IDLE, WAIT, TRAIL or GAP.
- Counter width is clog2(CLK_DIV+1). With CLK_DIV=1, SCK toggles every clk cycle.

Test Plan:
- Reset: assert rst for 3 cycles with tx_valid=1 -> tx_ready=0, SS=1, SCK=0, MOSI=0, rx_valid=0. One cycle after rst falls, tx_ready=1.
- Single word, CLK_DIV=4, with a slave model returning 0x3C:
  - Stimulus: send 0xA5 with last=1.
  - MOSI sampled on SCK rises = 1,0,1,0,0,1,0,1.
  - 8 SCK pulses, each 4 clk high and 4 clk low.
  - rx_valid pulses once with rx_data=0x3C, 64 cycles after accept.
  - SS rises at +68; tx_ready=1 at +72.
- Burst: send 0x33 (last=0) then 0x34 (last=1) back-to-back -> SS low continuously, 16 SCK rises, two rx_valid pulses 65 cycles apart, SS high 4 cycles after the second.
- Stall: after 0x33 (last=0), hold tx_valid=0 for 50 cycles -> SS=0, SCK=0, tx_ready=1, busy=1 throughout. Then sending 0xFF (last=1) completes normally.
- Reset mid-word: assert rst after the 3rd SCK rise -> next cycle SS=1, SCK=0, no rx_valid. A following 0x81 transfer produces correct MOSI and rx.
- CLK_DIV=1: send 0x5A with last=1 -> SCK period 2 clk, rx_valid 16 cycles after accept, tx_ready back at +18.
